uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver that sits directly downstream of the UART transmitter: it deserializes the asynchronous `rx` line into DATA_BITS-wide words. Each word is presented on a valid/ready output handshake with a one-entry holding register. It is used in loopback with the TX peripheral and as the host-input path for the SoC bus peripheral wrapper. Frame format is 8N1 by default: 1 start bit (low), DATA_BITS data bits LSB first, STOP_BITS stop bits (high).

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 9600, line rate in bit/s
- DATA_BITS, 8, data bits per frame (5..9)
- STOP_BITS, 1, stop bits checked per frame (1..2)
- PERIOD (localparam), CLK_FREQ/BAUD_RATE, clock cycles per bit (integer division)
- HALF (localparam), PERIOD/2, offset to mid-bit

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset; everything clears immediately while rst==0
- rx  input  1  serial line, asynchronous to clk, idle high
- data  output  DATA_BITS  received word; stable while data_valid==1
- data_valid  output  1  word available
- data_ready  input  1  consumer accepts; transfer when data_valid && data_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: frame completed while holding register still full

Behaviour:
- Synchronizer: rx passes through 2 flops (reset value 1) before any use, giving 2 cycles of input latency. All references to "rx" below mean the synchronized value rx_s.
- Reset values: data=0, data_valid=0, frame_err=0, overrun=0, state=IDLE, counters=0. Reset mid-frame abandons the frame with no pulses.
- State machine:
  - IDLE: on rx_s==0 go to START and set clk_cnt=0.
  - START: count to HALF-1, then sample rx_s.
    - If rx_s==1 (glitch), return to IDLE silently.
    - Else go to DATA with clk_cnt=0, bit_cnt=0.
  - DATA: every PERIOD cycles (clk_cnt==PERIOD-1) sample rx_s into shift register bit bit_cnt (LSB first).
    - After DATA_BITS samples go to STOP.
  - STOP: every PERIOD cycles sample one stop bit.
    - Any stop sample ==0 sets an internal error flag.
    - After STOP_BITS samples, complete the frame and go to IDLE.
- Frame completion (same cycle as the last stop sample):
  - Error flag set: frame_err=1 for exactly one cycle; word discarded; data_valid unchanged.
  - Else, holding register empty, or being emptied this cycle (data_valid && data_ready): data<=shift register, data_valid<=1.
  - Else (still full): overrun=1 for one cycle; new word dropped; held word and data_valid unchanged.
- Next frame: after returning to IDLE from STOP, the next falling edge is detected immediately. No extra idle time is required, since the stop sample is taken mid-bit.
- Handshake:
  - data_valid clears the cycle after data_valid && data_ready.
  - data_ready while data_valid==0 is ignored.
  - data and data_valid are registered outputs; there is no combinational path from data_ready to them.
- Latency: data_valid rises (2 + HALF + (DATA_BITS+STOP_BITS)·PERIOD) ± 1 cycles after the rx falling edge of the start bit.
- Counter widths: clk_cnt is $clog2(PERIOD)+1 bits; bit_cnt is $clog2(DATA_BITS+1) bits; no wrap-around at max values.

Decomposition:
- Package uart_pkg:
  - uart_rx_state_t enum {IDLE, START, DATA, STOP}.
  - Function calc_period(clk_freq, baud) shared with TX.
- Sub-module uart_sync (2-flop synchronizer, reset value parameter), reusable for other async inputs.

Test Plan:
- Sim params CLK_FREQ=1000000, BAUD_RATE=100000 (PERIOD=10), data_ready=1. Drive frame 0xA5 -> one data_valid pulse with data=0xA5; frame_err=0; latency within 2+5+90 ±1 cycles.
- Loopback to uart_tx, sending 0x00, 0xFF, 0x55 back-to-back -> three words received in order, no errors.
- rx low for 3 cycles then high (glitch) -> returns to IDLE; no data_valid, frame_err, or overrun.
- Frame 0x3C with stop bit driven low -> frame_err pulses one cycle; data_valid stays 0.
- data_ready=0 and frames 0x11 then 0x22 sent -> data=0x11 held, overrun pulses at end of 2nd frame. Then raise data_ready -> 0x11 accepted, data_valid drops next cycle.
- Assert rst=0 mid-data-bits of 0x77, release, send 0x12 -> only 0x12 delivered; no pulses during or after reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-period helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

    // Clock cycles per bit, integer division; also used by the transmitter.
    function automatic int unsigned calc_period(input int unsigned clk_freq,
                                                input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // Shift the raw input through the two-stage chain.
    always_comb begin
        sync_d = {sync_q[0], d};
    end

    // Synchronizer flops, cleared to the idle level on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, LSB-first deserialization, one-entry
// holding register on a valid/ready output, framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned PERIOD = calc_period(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF   = PERIOD / 2;
    localparam int unsigned CW     = $clog2(PERIOD) + 1;
    localparam int unsigned BW     = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    logic rx_s;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (rx),
        .q     (rx_s)
    );

    uart_rx_state_t       state_q,   state_d;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 err_q,     err_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 valid_q,   valid_d;
    logic                 ferr_q,    ferr_d;
    logic                 ovr_q,     ovr_d;
    logic                 stop_bad;

    // Next-state, bit sampling, frame completion and output handshake.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        err_d     = err_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        stop_bad  = err_q | ~rx_s;

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                end
            end
            START: begin
                if (clk_cnt_q == CNT_HALF) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    // Shifting in at the MSB lands the first bit at the LSB
                    // once DATA_BITS samples have been taken.
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        err_d     = 1'b0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    err_d     = stop_bad;
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        err_d     = 1'b0;
                        state_d   = IDLE;
                        if (stop_bad) begin
                            ferr_d = 1'b1;
                        end else if (!valid_q || data_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            err_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            err_q     <= err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule
